// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ packet streams onto one FIFO write port.
// A grant lasts until the packet's last beat or MAX_BURST beats, whichever comes first.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_mask,
  output logic                          f_valid,
  output logic [ID_W+DATA_WIDTH:0]      f_data,
  input  logic                          f_ready,
  output logic                          busy,
  output logic [ID_W-1:0]               cur_id
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                r_state, w_state_nxt;
  logic [ID_W-1:0]       r_cur_id, w_cur_id_nxt;
  logic [ID_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic [ID_W-1:0]       w_win;
  logic [NUM_REQ-1:0]    w_elig;
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
  logic                  w_out_last;
  logic                  w_accept;
  int unsigned           w_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_elig = req_valid & req_mask;

  // Scanning downward lets the lowest circular offset from r_rr_ptr win.
  always_comb begin
    w_win = '0;
    w_idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = (32'(r_rr_ptr) + unsigned'(i)) % NUM_REQ;
      if (w_elig[ID_W'(w_idx)]) w_win = ID_W'(w_idx);
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state    <= S_IDLE;
      r_cur_id   <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_id   <= w_cur_id_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_id_nxt   = r_cur_id;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    f_valid        = 1'b0;
    req_ready      = '0;
    w_accept       = 1'b0;
    w_out_last     = req_last[r_cur_id] | (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    case (r_state)
      S_IDLE: begin
        if (|w_elig) begin
          w_state_nxt    = S_GRANT;
          w_cur_id_nxt   = w_win;
          w_beat_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        f_valid             = req_valid[r_cur_id];
        req_ready[r_cur_id] = f_ready;
        w_accept            = req_valid[r_cur_id] & f_ready;
        if (w_accept) begin
          if (w_out_last) begin
            w_state_nxt  = S_IDLE;
            w_rr_ptr_nxt = (r_cur_id == ID_W'(NUM_REQ - 1)) ? '0 : r_cur_id + ID_W'(1);
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign f_data = {r_cur_id, w_out_last, w_data[r_cur_id]};
  assign busy   = (r_state == S_GRANT);
  assign cur_id = r_cur_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin model.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned FW = IW + 1 + DW;

  logic           wclk, wrst;
  logic [NR-1:0]  req_valid, req_last, req_ready, req_mask;
  logic [NR*DW-1:0] req_data;
  logic           f_valid, f_ready, busy;
  logic [FW-1:0]  f_data;
  logic [IW-1:0]  cur_id;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW:0]   src_q [NR][$];
  logic [FW-1:0] exp_q [$];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .req_mask(req_mask),
    .f_valid(f_valid), .f_data(f_data), .f_ready(f_ready), .busy(busy), .cur_id(cur_id)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    wrst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; req_mask = '1; f_ready = 1'b0;
    repeat (2) @(negedge wclk);
    wrst = 1'b0;
  endtask

  task automatic set_beat(input int i, input logic [DW-1:0] d, input logic l);
    req_data[i*DW +: DW] = d;
    req_last[i] = l;
  endtask

  task automatic test_reset();
    wrst = 1'b1; req_valid = '1; req_last = '1; req_data = '1; req_mask = '1; f_ready = 1'b1;
    repeat (3) @(negedge wclk);
    #1;
    n_tests++;
    if ({busy, f_valid, req_ready, cur_id} !== {1'b0, 1'b0, 4'b0000, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got busy/fv/rdy/id=%b exp 0/0/0000/00", {busy, f_valid, req_ready, cur_id});
    end
    wrst = 1'b0;
  endtask

  task automatic test_single();
    logic [FW-1:0] e;
    do_reset();
    @(negedge wclk);
    req_valid = 4'b0001; set_beat(0, 8'h10, 1'b0); f_ready = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b exp 0", busy); end
    for (int b = 0; b < 3; b++) begin
      @(negedge wclk);
      set_beat(0, 8'(8'h10 + b), b == 2);
      #1;
      e = {2'd0, 1'(b == 2), 8'(8'h10 + b)};
      n_tests++;
      if ({busy, f_valid, req_ready, f_data} !== {1'b1, 1'b1, 4'b0001, e}) begin
        n_fail++;
        $display("FAIL single_beat%0d: got b/v/rdy/data=%b/%b/%b/%h exp 1/1/0001/%h", b, busy, f_valid, req_ready, f_data, e);
      end
    end
    @(negedge wclk);
    req_valid = '0;
    #1;
    n_tests++;
    if ({busy, f_valid} !== 2'b00) begin n_fail++; $display("FAIL single_after: got busy/fv=%b exp 00", {busy, f_valid}); end
  endtask

  task automatic test_round_robin();
    int got_id [$];
    int got_cyc [$];
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge wclk);
      if (c == 0) begin
        req_valid = '1; f_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_beat(i, 8'(i), 1'b1);
      end
      #1;
      if (f_valid && f_ready) begin got_id.push_back(int'(f_data[FW-1 -: IW])); got_cyc.push_back(c); end
    end
    n_tests++;
    if (got_id.size() != 6) begin n_fail++; $display("FAIL rr_count: got %0d grants exp 6", got_id.size()); end
    for (int k = 0; k < got_id.size() && k < 6; k++) begin
      n_tests++;
      if (got_id[k] != k % 4 || got_cyc[k] != 2 * k + 1) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got id=%0d cyc=%0d exp id=%0d cyc=%0d", k, got_id[k], got_cyc[k], k % 4, 2 * k + 1);
      end
    end
  endtask

  task automatic test_max_burst();
    logic [FW-1:0] got_d [$];
    int got_cyc [$];
    int exp_cyc [6] = '{1, 2, 3, 4, 6, 7};
    logic [FW-1:0] e;
    int k = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge wclk);
      f_ready = 1'b1;
      req_valid[1] = (k < 6);
      set_beat(1, 8'(8'h20 + k), k == 5);
      #1;
      if (f_valid && f_ready) begin got_d.push_back(f_data); got_cyc.push_back(c); k++; end
    end
    n_tests++;
    if (got_d.size() != 6) begin n_fail++; $display("FAIL burst_count: got %0d beats exp 6", got_d.size()); end
    for (int j = 0; j < got_d.size() && j < 6; j++) begin
      e = {2'd1, 1'(j == 3 || j == 5), 8'(8'h20 + j)};
      n_tests++;
      if (got_d[j] !== e || got_cyc[j] != exp_cyc[j]) begin
        n_fail++;
        $display("FAIL burst_beat%0d: got data=%h cyc=%0d exp data=%h cyc=%0d", j, got_d[j], got_cyc[j], e, exp_cyc[j]);
      end
    end
  endtask

  task automatic test_stall();
    logic [FW-1:0] got_d [$];
    int got_cyc [$];
    int exp_cyc [4] = '{1, 2, 8, 9};
    logic [FW-1:0] e;
    int k = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge wclk);
      f_ready = !(c >= 3 && c <= 7);
      req_valid[0] = (k < 4);
      set_beat(0, 8'(8'h30 + k), k == 3);
      #1;
      if (c >= 3 && c <= 7) begin
        n_tests++;
        if ({busy, f_valid, req_ready, f_data} !== {1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h32}) begin
          n_fail++;
          $display("FAIL stall_c%0d: got b/v/rdy/data=%b/%b/%b/%h exp 1/1/0000/032", c, busy, f_valid, req_ready, f_data);
        end
      end
      if (f_valid && f_ready) begin got_d.push_back(f_data); got_cyc.push_back(c); k++; end
    end
    n_tests++;
    if (got_d.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d beats exp 4", got_d.size()); end
    for (int j = 0; j < got_d.size() && j < 4; j++) begin
      e = {2'd0, 1'(j == 3), 8'(8'h30 + j)};
      n_tests++;
      if (got_d[j] !== e || got_cyc[j] != exp_cyc[j]) begin
        n_fail++;
        $display("FAIL stall_beat%0d: got data=%h cyc=%0d exp data=%h cyc=%0d", j, got_d[j], got_cyc[j], e, exp_cyc[j]);
      end
    end
  endtask

  task automatic test_mask();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge wclk);
      if (c == 0) begin req_valid = 4'b0100; req_mask = 4'b1011; set_beat(2, 8'h44, 1'b1); f_ready = 1'b1; end
      if (c == 4) req_mask = 4'b1111;
      #1;
      n_tests++;
      if (c < 5 && {busy, f_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL mask_idle_c%0d: got busy/fv=%b exp 00", c, {busy, f_valid});
      end else if (c == 5 && {busy, cur_id, f_valid, f_data} !== {1'b1, 2'd2, 1'b1, 2'd2, 1'b1, 8'h44}) begin
        n_fail++;
        $display("FAIL mask_grant: got b/id/v/data=%b/%0d/%b/%h exp 1/2/1/544", busy, cur_id, f_valid, f_data);
      end
    end
  endtask

  task automatic test_hold_grant();
    do_reset();
    @(negedge wclk);
    req_valid = 4'b0010; set_beat(1, 8'h50, 1'b0); f_ready = 1'b1;
    @(negedge wclk); #1;
    n_tests++;
    if ({f_valid, f_data} !== {1'b1, 2'd1, 1'b0, 8'h50}) begin
      n_fail++; $display("FAIL hold_beat0: got v/data=%b/%h exp 1/250", f_valid, f_data);
    end
    // Requester drops valid and loses its mask bit mid-grant; another requester appears.
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk);
      req_valid = 4'b0001; req_mask = 4'b1101; set_beat(0, 8'h60, 1'b1);
      #1;
      n_tests++;
      if ({busy, f_valid, cur_id, req_ready} !== {1'b1, 1'b0, 2'd1, 4'b0010}) begin
        n_fail++;
        $display("FAIL hold_gap%0d: got b/v/id/rdy=%b/%b/%0d/%b exp 1/0/1/0010", c, busy, f_valid, cur_id, req_ready);
      end
    end
    @(negedge wclk);
    req_valid = 4'b0011; set_beat(1, 8'h51, 1'b1);
    #1;
    n_tests++;
    if ({f_valid, f_data} !== {1'b1, 2'd1, 1'b1, 8'h51}) begin
      n_fail++; $display("FAIL hold_beat1: got v/data=%b/%h exp 1/351", f_valid, f_data);
    end
    @(negedge wclk);
    req_valid = 4'b0001;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got busy=%b exp 0", busy); end
    @(negedge wclk); #1;
    n_tests++;
    if ({busy, cur_id, f_data} !== {1'b1, 2'd0, 2'd0, 1'b1, 8'h60}) begin
      n_fail++; $display("FAIL hold_next: got b/id/data=%b/%0d/%h exp 1/0/160", busy, cur_id, f_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge wclk);
    req_valid = 4'b1000; set_beat(3, 8'h70, 1'b0); f_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge wclk);
      set_beat(3, 8'(8'h70 + b), 1'b0);
      #1;
      n_tests++;
      if ({f_valid, f_data} !== {1'b1, 2'd3, 1'b0, 8'(8'h70 + b)}) begin
        n_fail++; $display("FAIL rstmid_beat%0d: got v/data=%b/%h exp 1/%h", b, f_valid, f_data, {2'd3, 1'b0, 8'(8'h70 + b)});
      end
    end
    @(negedge wclk);
    wrst = 1'b1;
    #1;
    n_tests++;
    if ({f_valid, busy, req_ready, cur_id} !== {1'b0, 1'b0, 4'b0000, 2'd0}) begin
      n_fail++; $display("FAIL rstmid_abort: got v/b/rdy/id=%b exp 0/0/0000/00", {f_valid, busy, req_ready, cur_id});
    end
    @(negedge wclk);
    wrst = 1'b0; req_valid = 4'b1001; set_beat(0, 8'h01, 1'b1); set_beat(3, 8'h73, 1'b1);
    #1;
    n_tests++;
    if ({busy, f_valid} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle: got busy/fv=%b exp 00", {busy, f_valid}); end
    @(negedge wclk); #1;
    n_tests++;
    if ({busy, f_data} !== {1'b1, 2'd0, 1'b1, 8'h01}) begin
      n_fail++; $display("FAIL rstmid_first: got b/data=%b/%h exp 1/101", busy, f_data);
    end
  endtask

  // Expected stream: grant chunks of up to MB beats, round-robin over requesters with data.
  task automatic build_model();
    logic [DW:0] cp [NR][$];
    logic [DW:0] bt;
    logic lst;
    int ptr = 0;
    int sel, cnt, j;
    for (int i = 0; i < NR; i++) cp[i] = src_q[i];
    exp_q.delete();
    while (1) begin
      sel = -1;
      for (int s = 0; s < NR; s++) begin
        j = (ptr + s) % NR;
        if (sel < 0 && cp[j].size() > 0) sel = j;
      end
      if (sel < 0) break;
      cnt = 0; lst = 1'b0;
      while (!lst) begin
        bt = cp[sel].pop_front();
        cnt++;
        lst = bt[DW] || (cnt == MB);
        exp_q.push_back({IW'(sel), lst, bt[DW-1:0]});
      end
      ptr = (sel + 1) % NR;
    end
  endtask

  task automatic test_random();
    logic [FW-1:0] e;
    int len, cyc;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < NR; i++) begin
        src_q[i].delete();
        for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) src_q[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
      end
      build_model();
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 2000) begin
        @(negedge wclk);
        cyc++;
        for (int i = 0; i < NR; i++) begin
          req_valid[i] = (src_q[i].size() > 0);
          if (src_q[i].size() > 0) set_beat(i, src_q[i][0][DW-1:0], src_q[i][0][DW]);
        end
        f_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (f_valid && f_ready) begin
          e = exp_q.pop_front();
          n_tests++;
          if (f_data !== e || req_ready !== (NR'(1) << e[FW-1 -: IW])) begin
            n_fail++;
            $display("FAIL random_r%0d_c%0d: got data=%h rdy=%b exp data=%h", r, cyc, f_data, req_ready, e);
          end
          for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
        end
      end
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++; $display("FAIL random_r%0d_timeout: got %0d beats left exp 0", r, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_stall();
    test_mask();
    test_hold_grant();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one FIFO write port, legal range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: requester payload width.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per grant, legal range 2..256.
REQ-004 SHALL have derived localparam ID_W = $clog2(NUM_REQ): requester ID width.
REQ-005 SHALL have port wclk  input  1: write-domain clock; all logic is posedge wclk.
REQ-006 SHALL have port wrst  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  NUM_REQ: per-requester beat valid.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH: payload, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_last  input  NUM_REQ: last beat of packet.
REQ-010 SHALL have port req_ready  output  NUM_REQ: beat accepted when req_valid[i] & req_ready[i].
REQ-011 SHALL have port req_mask  input  NUM_REQ: 1 = requester eligible for arbitration.
REQ-012 SHALL have port f_valid  output  1: drives FIFO w_valid.
REQ-013 SHALL have port f_data  output  ID_W+1+DATA_WIDTH: {id, last, payload}, drives FIFO w_data.
REQ-014 SHALL have port f_ready  input  1: FIFO w_ready.
REQ-015 SHALL have port busy  output  1: high in GRANT state.
REQ-016 SHALL have port cur_id  output  ID_W: currently or last granted requester.

Function
REQ-017 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-018 In IDLE, f_valid and all req_ready SHALL be 0; eligible = req_valid & req_mask.
REQ-019 In IDLE with eligible nonzero, the winner SHALL be the first eligible index found searching circularly upward from rr_ptr; next edge: state GRANT, cur_id <= winner, beat_cnt <= 0.
REQ-020 In GRANT, f_valid SHALL equal req_valid[cur_id]; req_ready[cur_id] SHALL equal f_ready; all other req_ready SHALL be 0.
REQ-021 In GRANT, f_data SHALL be {cur_id, out_last, req_data[cur_id]}, with out_last = req_last[cur_id] | (beat_cnt == MAX_BURST-1).
REQ-022 An accepted beat (f_valid & f_ready) with out_last=0 SHALL increment beat_cnt by 1.
REQ-023 An accepted beat with out_last=1 SHALL return the FSM to IDLE and set rr_ptr <= (cur_id+1) mod NUM_REQ.
REQ-024 A burst reaching MAX_BURST beats SHALL be truncated with forced last; the requester's remaining beats SHALL compete anew.
REQ-025 req_valid[cur_id] deasserting mid-burst SHALL hold the grant with f_valid=0; there is no timeout.
REQ-026 f_ready low SHALL hold the FSM, beat_cnt and f_data unchanged (with stable requester inputs).
REQ-027 req_mask changes SHALL only affect the next IDLE arbitration, never an active grant.
REQ-028 There SHALL be exactly one IDLE cycle between consecutive grants; within a grant, throughput SHALL be 1 beat/cycle.
REQ-029 busy SHALL equal (state == GRANT); cur_id SHALL hold its value in IDLE.

Reset
REQ-030 wrst SHALL asynchronously force state=IDLE, rr_ptr=0, beat_cnt=0, cur_id=0, f_valid=0, req_ready=0, busy=0.
REQ-031 wrst mid-burst SHALL abandon the burst with no further beats; first post-reset arbitration SHALL start from index 0.

Verification
REQ-032 req0 sends 3 beats, last on beat 3, f_ready=1 -> busy 1 cycle after req_valid; 3 f_valid beats with id=0; last=1 only on beat 3; then 1 IDLE cycle.
REQ-033 All 4 requesters continuously valid, single-beat packets, mask=4'b1111 -> grant order 0,1,2,3,0,1.
REQ-034 MAX_BURST=4, req1 alone sends 6 beats, last on beat 6 -> beat 4 carries forced last=1; IDLE; regrant to req1; beats 5-6 follow, last on beat 6.
REQ-035 f_ready=0 for 5 cycles after beat 2 -> f_valid=1, f_data stable, req_ready=0, beat_cnt=2 throughout; beat 3 accepted when f_ready returns.
REQ-036 req_mask=4'b1011 with only req2 valid -> no grant, busy=0; setting mask bit 2 -> grant to req2 next cycle.
REQ-037 wrst asserted in GRANT after 2 beats of req3; req0 and req3 valid after release -> f_valid=0 immediately; first grant goes to req0.
